// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed single-MAC FIR core.
// One accepted sample produces one output after TAPS MAC steps; coefficients
// come from an external 1-cycle synchronous-read ROM addressed one tap per cycle.
module fir_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int ADDR_WIDTH = $clog2(TAPS),
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [ADDR_WIDTH-1:0] coef_addr_o,
    input  logic [COEF_WIDTH-1:0] coef_data_i,
    output logic [ACC_WIDTH-1:0]  m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0]  TAPS_W   = PTR_WIDTH'(TAPS);
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FLUSH,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0]        delay_line [TAPS];
    logic [ADDR_WIDTH-1:0]        wr_ptr;
    logic [ADDR_WIDTH-1:0]        wr_ptr_next;
    logic [ADDR_WIDTH-1:0]        tap;
    logic [PTR_WIDTH-1:0]         rd_sum;
    logic [ADDR_WIDTH-1:0]        rd_idx;
    logic signed [DATA_WIDTH-1:0] sample_reg;
    logic                         acc_en;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  product_ext;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic                         accept;

    assign accept = s_valid_i && s_ready_o;

    // State register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/address outputs
    always_comb begin
        state_next  = state;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        coef_addr_o = '0;
        case (state)
            IDLE: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                coef_addr_o = tap;
                if (tap == LAST_TAP) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = OUT;
            end
            OUT: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Circular read index (wr_ptr - tap) mod TAPS; widened so non power-of-two TAPS wraps correctly
    always_comb begin
        rd_sum = {1'b0, wr_ptr} + TAPS_W - {1'b0, tap};
        if (rd_sum >= TAPS_W) begin
            rd_sum = rd_sum - TAPS_W;
        end
        rd_idx      = rd_sum[ADDR_WIDTH-1:0];
        wr_ptr_next = (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
    end

    // Signed product of ROM word and aligned sample, sign-extended into the accumulator
    always_comb begin
        product     = $signed(coef_data_i) * sample_reg;
        product_ext = {{(ACC_WIDTH - PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
        acc_sum     = acc + product_ext;
    end

    // Sample history: write on accept, cleared by reset
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                delay_line[i] <= '0;
            end
        end else if (accept) begin
            delay_line[wr_ptr] <= s_data_i;
        end
    end

    // Tap sequencing, ROM-latency alignment, accumulation and result capture
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr     <= '0;
            tap        <= '0;
            sample_reg <= '0;
            acc_en     <= 1'b0;
            acc        <= '0;
            m_data_o   <= '0;
        end else begin
            // acc_en marks the cycle in which the ROM word for the previous address is present
            acc_en <= (state == CALC);
            if (accept) begin
                tap <= '0;
                acc <= '0;
            end
            if (state == CALC) begin
                sample_reg <= delay_line[rd_idx];
                if (tap != LAST_TAP) begin
                    tap <= tap + 1'b1;
                end
            end
            if (acc_en) begin
                acc <= acc_sum;
            end
            if (state == FLUSH) begin
                wr_ptr   <= wr_ptr_next;
                m_data_o <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq with TAPS=4 and a 1-cycle registered coefficient ROM.
module tb_fir_mac_seq;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 4;
    localparam int AW   = 2;
    localparam int ACCW = 34;

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [AW-1:0]   coef_addr;
    logic [CW-1:0]   coef_data = '0;
    logic [ACCW-1:0] m_data;
    logic            m_valid;
    logic            m_ready = 1'b1;

    logic signed [CW-1:0] h [TAPS];
    longint               hist [TAPS];
    longint               exp_q [$];
    longint               stim [8];

    int n_tests = 0;
    int n_fail  = 0;
    int bp_cycles = 0;

    fir_mac_seq #(
        .DATA_WIDTH(DW),
        .COEF_WIDTH(CW),
        .TAPS(TAPS),
        .ADDR_WIDTH(AW),
        .ACC_WIDTH(ACCW)
    ) dut (
        .clk_i(clk),
        .arstn_i(arstn),
        .s_data_i(s_data),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .coef_addr_o(coef_addr),
        .coef_data_i(coef_data),
        .m_data_o(m_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;

    // Coefficient ROM: synchronous read, one cycle latency
    always @(posedge clk) coef_data <= h[coef_addr];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Sink backpressure: stall the next bp_cycles OUT cycles
    initial begin
        forever begin
            @(negedge clk);
            if (bp_cycles > 0 && m_valid) begin
                m_ready = 1'b0;
                bp_cycles--;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Monitor: model on accept, compare on output, timing checks
    int cyc = 0;
    int acc_cyc = 0;
    int last_acc = 0;
    bit pending = 0;
    bit have_last = 0;
    bit bp_since = 0;
    bit prev_valid = 0;

    always @(negedge clk) begin
        int ph;
        longint y;
        #1;
        cyc++;
        if (!arstn) begin
            exp_q.delete();
            for (int i = 0; i < TAPS; i++) hist[i] = 0;
            pending = 0;
            have_last = 0;
            prev_valid = 0;
            bp_since = 0;
        end else begin
            if (!s_valid) have_last = 0;
            if (pending) begin
                ph = cyc - acc_cyc;
                if (ph >= 1 && ph <= TAPS) check("coef_addr", coef_addr, ph - 1);
                else if (ph == TAPS + 1) check("coef_addr_flush", coef_addr, 0);
            end
            if (m_valid && !prev_valid && pending) begin
                check("latency", cyc - acc_cyc, TAPS + 2);
                pending = 0;
            end
            if (m_valid && !m_ready) begin
                bp_since = 1;
                check("bp_s_ready", s_ready, 0);
                if (exp_q.size() > 0) check("bp_hold", $signed(m_data), exp_q[0]);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious_out", m_valid, 0);
                else check("m_data", $signed(m_data), exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                if (have_last && !bp_since) check("accept_spacing", cyc - last_acc, TAPS + 3);
                for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = longint'($signed(s_data));
                y = 0;
                for (int i = 0; i < TAPS; i++) y += longint'(h[i]) * hist[i];
                exp_q.push_back(y);
                last_acc = cyc;
                have_last = 1;
                bp_since = 0;
                acc_cyc = cyc;
                pending = 1;
            end
            prev_valid = m_valid;
        end
    end

    // Drive stim[0..n-1] with s_valid held high across the whole sequence
    task automatic send_seq(input int n);
        int waited;
        @(negedge clk);
        s_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_data = DW'(stim[i]);
            waited = 0;
            #2;
            while (!s_ready && waited < 200) begin
                @(negedge clk);
                #2;
                waited++;
            end
            if (!s_ready) begin
                check("accept_timeout", s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i + 1 < n) @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((exp_q.size() != 0 || m_valid) && waited < 300) begin
            @(negedge clk);
            #2;
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #3;
        arstn = 1'b0;
        s_valid = 1'b0;
        #1;
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, $signed(m_data), 0);
        check({tag, "_coef_addr"}, coef_addr, 0);
        repeat (2) @(negedge clk);
        #3;
        arstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] r;

        h = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        do_reset("rst0");

        // Impulse: 1,0,0,0,0 -> 1,2,3,4,0
        stim = '{1, 0, 0, 0, 0, 0, 0, 0};
        send_seq(5);
        drain();

        // Step: five ones -> 1,3,6,10,10 (write pointer wraps)
        do_reset("rst1");
        stim = '{1, 1, 1, 1, 1, 0, 0, 0};
        send_seq(5);
        drain();

        // Backpressure: first output stalled 10 cycles, history carried over
        bp_cycles = 10;
        stim = '{2, -3, 5, 0, 0, 0, 0, 0};
        send_seq(3);
        drain();

        // Sign extremes: all -32768 -> final 2^32
        h = '{default: 16'sh8000};
        do_reset("rst2");
        stim = '{-32768, -32768, -32768, -32768, 0, 0, 0, 0};
        send_seq(4);
        drain();

        // Random coefficients and samples
        for (int i = 0; i < TAPS; i++) h[i] = 16'($urandom);
        do_reset("rst3");
        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom);
            stim[i] = r;
        end
        send_seq(8);
        drain();

        // Reset mid-CALC: 5 completes, 7 is discarded, then a clean impulse
        h = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        do_reset("rst4");
        stim = '{5, 0, 0, 0, 0, 0, 0, 0};
        send_seq(1);
        drain();
        stim = '{7, 0, 0, 0, 0, 0, 0, 0};
        send_seq(1);
        repeat (2) @(negedge clk);
        do_reset("rst_mid");
        stim = '{1, 0, 0, 0, 0, 0, 0, 0};
        send_seq(4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
